// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I/RV32E core (FETCH/DECODE/EXEC/WB/HALT); CPU_INSTRET_EN adds an instret counter.
// Latency: 4 cycles per instruction when imem_valid arrives in the first FETCH cycle, +1 per cycle imem_valid is low.
// Backpressure: FETCH holds imem_req and imem_addr until imem_valid; an illegal instruction parks the core in HALT until reset.
module rv_multicycle_core #(
  parameter int          NREGS    = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_rdata,
  input  logic [2:0]         dbg_sel,
  output logic [31:0]        dbg_data,
  output logic [3:0]         fr,
  output logic               halted
);

  localparam int         RW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  if (NREGS != 32 && NREGS != 16) begin : g_bad_nregs
    $error("rv_multicycle_core: NREGS must be 32 or 16");
  end

  // One-hot codes double as the dbg_sel=7 view of the state.
  typedef enum logic [4:0] {
    S_FETCH  = 5'b00001,
    S_DECODE = 5'b00010,
    S_EXEC   = 5'b00100,
    S_WB     = 5'b01000,
    S_HALT   = 5'b10000
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a_q, b_q, f_q;
  logic [31:0] regs [NREGS];
  logic [31:0] instret;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_r, is_i, is_lui;
  logic        f7_ok, regs_ok, legal;
  logic [31:0] imm_i, lui_val, rd_a, rd_b;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign is_r    = (opcode == 7'b0110011);
  assign is_i    = (opcode == 7'b0010011);
  assign is_lui  = (opcode == 7'b0110111);
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign lui_val = {ir[31:12], 12'b0};

  // Only sub/sra (R) and srai (I) may carry funct7=0100000; shift immediates allow nothing else.
  always_comb begin
    f7_ok = 1'b1;
    if (is_r) begin
      f7_ok = (funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    end else if (is_i && funct3 == 3'b001) begin
      f7_ok = (funct7 == 7'b0000000);
    end else if (is_i && funct3 == 3'b101) begin
      f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    end
  end

  assign regs_ok = ({1'b0, rd} < NR) &&
                   (!(is_r || is_i) || ({1'b0, rs1} < NR)) &&
                   (!is_r || ({1'b0, rs2} < NR));
  assign legal   = (is_r || is_i || is_lui) && f7_ok && regs_ok;

  assign rd_a = (rs1 == 5'd0) ? 32'h0 : regs[rs1[RW-1:0]];
  assign rd_b = (rs2 == 5'd0) ? 32'h0 : regs[rs2[RW-1:0]];

  logic [31:0] op_b, alu_y;
  logic [32:0] sum, diff;
  logic [4:0]  shamt;
  logic        alu_cf, alu_of;

  assign op_b  = is_r ? b_q : imm_i;
  assign sum   = {1'b0, a_q} + {1'b0, op_b};
  assign diff  = {1'b0, a_q} - {1'b0, op_b};
  assign shamt = op_b[4:0];

  always_comb begin
    alu_y  = 32'h0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (funct3)
      3'b000: begin
        if (is_r && funct7[5]) begin
          alu_y  = diff[31:0];
          alu_cf = diff[32];
          alu_of = (a_q[31] != op_b[31]) && (diff[31] != a_q[31]);
        end else begin
          alu_y  = sum[31:0];
          alu_cf = sum[32];
          alu_of = (a_q[31] == op_b[31]) && (sum[31] != a_q[31]);
        end
      end
      3'b001: alu_y = a_q << shamt;
      3'b010: alu_y = {31'b0, $signed(a_q) < $signed(op_b)};
      3'b011: alu_y = {31'b0, a_q < op_b};
      3'b100: alu_y = a_q ^ op_b;
      3'b101: alu_y = funct7[5] ? 32'($signed(a_q) >>> shamt) : (a_q >> shamt);
      3'b110: alu_y = a_q | op_b;
      default: alu_y = a_q & op_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   halted    = 1'b1;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= PC_RESET;
      ir  <= 32'h0;
      a_q <= 32'h0;
      b_q <= 32'h0;
      f_q <= 32'h0;
      fr  <= 4'h0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
    end else begin
      case (state)
        S_FETCH: if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        S_EXEC: begin
          if (is_lui) begin
            f_q <= lui_val;
          end else begin
            f_q <= alu_y;
            fr  <= {alu_y == 32'h0, alu_cf, alu_of, alu_y[31]};
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd[RW-1:0]] <= f_q;
          pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_INSTRET_EN
  always_ff @(posedge clk) begin
    if (!rst_n)              instret <= 32'h0;
    else if (state == S_WB)  instret <= instret + 32'd1;
  end
`else
  assign instret = 32'h0;
`endif

  assign imem_addr = pc[IMEM_AW-1:0];

  always_comb begin
    dbg_data = 32'h0;
    case (dbg_sel)
      3'd0: dbg_data = pc;
      3'd1: dbg_data = ir;
      3'd2: dbg_data = f_q;
      3'd3: dbg_data = a_q;
      3'd4: dbg_data = b_q;
      3'd5: dbg_data = f_q;
      3'd6: dbg_data = instret;
      default: dbg_data = {27'b0, state};
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Randomised bench for rv_multicycle_core: a behavioural ISA model predicts PC, IR, operands, result, flags and instret.
// A second RV32E instance covers the register-range checks.
module tb_rv_multicycle_core;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n, imem_req, imem_valid, halted;
  logic [31:0] imem_addr, imem_rdata, dbg_data;
  logic [2:0]  dbg_sel;
  logic [3:0]  fr;
  logic        e_req, e_valid, e_halted;
  logic [15:0] e_addr;
  logic [31:0] e_rdata, e_dbg;
  logic [2:0]  e_sel;
  logic [3:0]  e_fr;

  rv_multicycle_core #(.NREGS(32), .PC_RESET(32'h0), .IMEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .fr(fr), .halted(halted));

  rv_multicycle_core #(.NREGS(16), .PC_RESET(32'h0000_0100), .IMEM_AW(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .imem_req(e_req), .imem_addr(e_addr),
    .imem_valid(e_valid), .imem_rdata(e_rdata), .dbg_sel(e_sel),
    .dbg_data(e_dbg), .fr(e_fr), .halted(e_halted));

`ifdef CPU_INSTRET_EN
  localparam bit INSTRET_EN = 1'b1;
`else
  localparam bit INSTRET_EN = 1'b0;
`endif
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_x [32];
  logic [31:0] m_pc, m_ir, m_a, m_b, m_f, m_instret;
  logic [3:0]  m_fr;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] rand_legal();
    int          k   = $urandom_range(0, 99);
    logic [4:0]  rd  = 5'($urandom);
    logic [4:0]  rs1 = 5'($urandom);
    logic [4:0]  rs2 = 5'($urandom);
    logic [2:0]  f3  = 3'($urandom);
    logic        alt = 1'($urandom);
    logic [11:0] imm = 12'($urandom);
    if (k < 40) return enc_r((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00, f3, rd, rs1, rs2);
    if (k < 85) begin
      if (f3 == 3'd1) imm[11:5] = 7'h00;
      if (f3 == 3'd5) imm[11:5] = alt ? 7'h20 : 7'h00;
      return enc_i(f3, rd, rs1, imm);
    end
    return enc_lui(rd, 20'($urandom));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    m_pc = 32'h0; m_ir = 32'h0; m_a = 32'h0; m_b = 32'h0; m_f = 32'h0;
    m_fr = 4'h0; m_instret = 32'h0;
  endtask

  // Architectural effect of one legal instruction, computed with 64-bit signed arithmetic.
  task automatic ref_exec(input logic [31:0] ins);
    logic [31:0] a, b, y;
    longint      sa, sb, s;
    logic        cf, of;
    int          sh;
    m_ir = ins;
    m_a  = m_x[ins[19:15]];
    m_b  = m_x[ins[24:20]];
    a    = m_a;
    b    = (ins[6:0] == 7'h33) ? m_b : {{20{ins[31]}}, ins[31:20]};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(b[4:0]);
    cf = 1'b0; of = 1'b0; y = 32'h0;
    if (ins[6:0] == 7'h37) begin
      y = {ins[31:12], 12'h000};
    end else begin
      case (ins[14:12])
        3'd0: if (ins[6:0] == 7'h33 && ins[30]) begin
                s = sa - sb; y = s[31:0]; cf = (longint'(a) < longint'(b)); of = (s > MAXS) || (s < MINS);
              end else begin
                s = sa + sb; y = s[31:0]; cf = (longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF;
                of = (s > MAXS) || (s < MINS);
              end
        3'd1: y = 32'(longint'(a) << sh);
        3'd2: y = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: y = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        3'd4: y = a ^ b;
        3'd5: y = ins[30] ? 32'(sa >>> sh) : 32'(longint'(a) >>> sh);
        3'd6: y = a | b;
        default: y = a & b;
      endcase
      m_fr = {y == 32'h0, cf, of, y[31]};
    end
    m_f = y;
    if (ins[11:7] != 5'd0) m_x[ins[11:7]] = y;
    m_pc = m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic read_dbg(input logic [2:0] s, output logic [31:0] v);
    dbg_sel = s; #1; v = dbg_data;
  endtask
  task automatic read_dbg_e(input logic [2:0] s, output logic [31:0] v);
    e_sel = s; #1; v = e_dbg;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0; imem_valid = 1'b0; e_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one fetch with the given wait states and checks the fetch port each FETCH cycle.
  task automatic exec_instr(input logic [31:0] ins, input int waits);
    imem_valid = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        n_err++; $display("FAIL fetch_port: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, m_pc);
      end
      if (w < waits) begin imem_rdata = $urandom; @(posedge clk); #1; end
    end
    imem_valid = 1'b1; imem_rdata = ins;
    @(posedge clk); #1;
    imem_valid = 1'b0; imem_rdata = $urandom;
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL decode_req: got %b, expected 0", imem_req); end
    repeat (3) @(posedge clk);
    #1 ref_exec(ins);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp [8];
    rst_n = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h0030_0093; e_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; imem_valid = 1'b0;
    model_reset();
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    for (int s = 0; s < 8; s++) begin
      read_dbg(3'(s), v);
      n_vec++; if (v !== exp[s]) begin n_err++; $display("FAIL reset_dbg%0d: got %h, expected %h", s, v, exp[s]); end
    end
    n_vec++; if ({imem_req, halted, fr} !== 6'b100000) begin
      n_err++; $display("FAIL reset_outs: req/halted/fr=%b, expected 100000", {imem_req, halted, fr});
    end
  endtask

  task automatic test_basic_alu();
    logic [31:0] v;
    int c0;
    do_reset(1);
    c0 = cyc;
    exec_instr(enc_i(3'd0, 5'd1, 5'd0, 12'd5), 0);
    exec_instr(enc_i(3'd0, 5'd2, 5'd0, 12'hFFB), 0);
    exec_instr(enc_r(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 0);
    n_vec++; if (cyc - c0 !== 12) begin n_err++; $display("FAIL basic_cycles: got %0d, expected 12", cyc - c0); end
    read_dbg(3'd5, v);
    n_vec++; if (v !== 32'h0 || v !== m_f) begin n_err++; $display("FAIL basic_x3: got %h, expected 0", v); end
    n_vec++; if (fr !== 4'b1100) begin n_err++; $display("FAIL basic_fr: got %b, expected 1100", fr); end
    read_dbg(3'd0, v);
    n_vec++; if (v !== 32'h0000_000C) begin n_err++; $display("FAIL basic_pc: got %h, expected 0000000c", v); end
    read_dbg(3'd4, v);
    n_vec++; if (v !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL basic_b: got %h, expected fffffffb", v); end
  endtask

  task automatic test_sub_overflow();
    logic [31:0] v;
    do_reset(1);
    exec_instr(enc_lui(5'd1, 20'h80000), 0);
    exec_instr(enc_i(3'd0, 5'd2, 5'd0, 12'd1), 1);
    exec_instr(enc_r(7'h20, 3'd0, 5'd3, 5'd1, 5'd2), 0);
    read_dbg(3'd2, v);
    n_vec++; if (v !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_result: got %h, expected 7fffffff", v); end
    n_vec++; if (fr !== 4'b0010) begin n_err++; $display("FAIL sub_fr: got %b, expected 0010", fr); end
    exec_instr(enc_lui(5'd4, 20'h00000), 2);
    n_vec++; if (fr !== 4'b0010) begin n_err++; $display("FAIL lui_keeps_fr: got %b, expected 0010", fr); end
    read_dbg(3'd5, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL lui_f: got %h, expected 0", v); end
  endtask

  task automatic test_wait_states();
    logic [31:0] v;
    int c0;
    do_reset(1);
    c0 = cyc;
    exec_instr(enc_i(3'd4, 5'd6, 5'd0, 12'h5A5), 3);
    exec_instr(enc_i(3'd6, 5'd7, 5'd6, 12'h00F), 3);
    n_vec++; if (cyc - c0 !== 14) begin n_err++; $display("FAIL wait_cycles: got %0d, expected 14", cyc - c0); end
    read_dbg(3'd6, v);
    n_vec++; if (v !== (INSTRET_EN ? 32'd2 : 32'd0)) begin
      n_err++; $display("FAIL wait_instret: got %0d, expected %0d", v, INSTRET_EN ? 2 : 0);
    end
    read_dbg(3'd5, v);
    n_vec++; if (v !== m_f) begin n_err++; $display("FAIL wait_f: got %h, expected %h", v, m_f); end
  endtask

  task automatic test_x0();
    logic [31:0] v;
    exec_instr(enc_i(3'd0, 5'd0, 5'd0, 12'd7), 0);
    read_dbg(3'd5, v);
    n_vec++; if (v !== 32'd7) begin n_err++; $display("FAIL x0_f: got %h, expected 7", v); end
    exec_instr(enc_r(7'h00, 3'd0, 5'd5, 5'd0, 5'd0), 0);
    read_dbg(3'd3, v);
    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL x0_read: got %h, expected 0", v); end
  endtask

  task automatic test_random();
    logic [31:0] v, ins;
    logic [31:0] exp [8];
    for (int i = 0; i < 160; i++) begin
      ins = rand_legal();
      exec_instr(ins, $urandom_range(0, 2));
      exp = '{m_pc, m_ir, m_f, m_a, m_b, m_f, INSTRET_EN ? m_instret : 32'h0, 32'h1};
      for (int s = 0; s < 8; s++) begin
        read_dbg(3'(s), v);
        n_vec++; if (v !== exp[s]) begin
          n_err++; $display("FAIL rand%0d_dbg%0d: ins=%h got %h, expected %h", i, s, ins, v, exp[s]);
        end
      end
      n_vec++; if (fr !== m_fr || halted !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_fr: ins=%h fr=%b halted=%b, expected fr=%b halted=0", i, ins, fr, halted, m_fr);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    logic [31:0] bad [5];
    bad[0] = 32'hFFFF_FFFF;
    bad[1] = enc_r(7'h01, 3'd0, 5'd3, 5'd1, 5'd2);
    bad[2] = enc_i(3'd1, 5'd3, 5'd1, 12'h401);
    bad[3] = {12'h0, 5'd1, 3'd2, 5'd3, 7'h03};
    bad[4] = enc_r(7'h20, 3'd4, 5'd3, 5'd1, 5'd2);
    for (int k = 0; k < 5; k++) begin
      do_reset(1);
      exec_instr(enc_i(3'd0, 5'd1, 5'd0, 12'd1), 0);
      imem_valid = 1'b1; imem_rdata = bad[k];
      @(posedge clk); #1;
      n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL ill%0d_early: halted=%b in DECODE, expected 0", k, halted); end
      @(posedge clk); #1;
      n_vec++; if (halted !== 1'b1 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL ill%0d_halt: halted=%b req=%b, expected 1/0", k, halted, imem_req);
      end
      repeat (3) @(posedge clk);
      #1 read_dbg(3'd0, v);
      n_vec++; if (v !== m_pc) begin n_err++; $display("FAIL ill%0d_pc: got %h, expected %h", k, v, m_pc); end
      read_dbg(3'd1, v);
      n_vec++; if (v !== bad[k]) begin n_err++; $display("FAIL ill%0d_ir: got %h, expected %h", k, v, bad[k]); end
      read_dbg(3'd7, v);
      n_vec++; if (v !== 32'h10 || halted !== 1'b1) begin
        n_err++; $display("FAIL ill%0d_state: got %h halted=%b, expected 10/1", k, v, halted);
      end
      do_reset(1);
      read_dbg(3'd0, v);
      n_vec++; if (halted !== 1'b0 || imem_req !== 1'b1 || v !== 32'h0) begin
        n_err++; $display("FAIL ill%0d_recover: halted=%b req=%b pc=%h, expected 0/1/0", k, halted, imem_req, v);
      end
    end
  endtask

  task automatic test_rv32e();
    logic [31:0] v;
    logic [31:0] bad [3];
    bad[0] = enc_r(7'h00, 3'd0, 5'd16, 5'd1, 5'd2);
    bad[1] = enc_r(7'h20, 3'd0, 5'd3, 5'd17, 5'd1);
    bad[2] = enc_r(7'h00, 3'd7, 5'd3, 5'd1, 5'd20);
    for (int k = 0; k < 3; k++) begin
      do_reset(1);
      e_valid = 1'b1; e_rdata = enc_i(3'd0, 5'd15, 5'd0, 12'd3);
      @(posedge clk); #1 e_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 read_dbg_e(3'd5, v);
      n_vec++; if (v !== 32'd3 || e_addr !== 16'h0104) begin
        n_err++; $display("FAIL e%0d_legal: f=%h addr=%h, expected 3/0104", k, v, e_addr);
      end
      e_valid = 1'b1; e_rdata = bad[k];
      @(posedge clk); #1 e_valid = 1'b0;
      @(posedge clk); #1 read_dbg_e(3'd0, v);
      n_vec++; if (e_halted !== 1'b1 || e_req !== 1'b0 || v !== 32'h0104) begin
        n_err++; $display("FAIL e%0d_range: halted=%b req=%b pc=%h, expected 1/0/00000104", k, e_halted, e_req, v);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] v;
    logic [31:0] exp [8];
    do_reset(1);
    exec_instr(enc_i(3'd0, 5'd5, 5'd0, 12'hFFF), 0);
    n_vec++; if (fr !== 4'b0001) begin n_err++; $display("FAIL mid_pre_fr: got %b, expected 0001", fr); end
    imem_valid = 1'b1; imem_rdata = enc_r(7'h00, 3'd0, 5'd7, 5'd5, 5'd5);
    @(posedge clk); #1 imem_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    for (int s = 0; s < 8; s++) begin
      read_dbg(3'(s), v);
      n_vec++; if (v !== exp[s]) begin n_err++; $display("FAIL mid_dbg%0d: got %h, expected %h", s, v, exp[s]); end
    end
    n_vec++; if (fr !== 4'h0) begin n_err++; $display("FAIL mid_fr: got %b, expected 0000", fr); end
    exec_instr(enc_r(7'h00, 3'd6, 5'd0, 5'd7, 5'd5), 0);
    read_dbg(3'd3, v);
    n_vec++; if (v !== 32'h0 || v !== m_a) begin n_err++; $display("FAIL mid_no_write: x7=%h, expected 0", v); end
  endtask

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0; dbg_sel = 3'd0;
    e_valid = 1'b0; e_rdata = 32'h0; e_sel = 3'd0;
    model_reset();
    test_reset();
    test_basic_alu();
    test_sub_overflow();
    test_wait_states();
    test_x0();
    test_random();
    test_illegal();
    test_rv32e();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
